// File: rtl/array_scheduler.sv
// array_scheduler
//   Round-robin owner of the shared N x N compute array. A granted job walks
//   LOAD (N cycles) -> COMPUTE (COMPUTE_CYCLES cycles) -> DRAIN (N cycles)
//   -> DONE (1 cycle), then the scheduler returns to IDLE.
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous active-high reset
//   req_i        per-requester job request (level, sampled only in IDLE)
//   abort_i      synchronous abort of the running job (LOAD/COMPUTE/DRAIN)
//   gnt_o        one-hot array owner, held from LOAD through DONE
//   done_o       one-cycle job-complete pulse to the owner
//   ld_sel_o     operand mux select (owner index), holds its value in IDLE
//   ld_en_o      operand load window
//   clr_o        accumulator clear, first LOAD cycle only
//   cmp_en_o     array compute enable
//   acc_valid_o  one-hot row strobe walking through DRAIN
//   busy_o       high in every state except IDLE
module array_scheduler #(
  parameter int N              = 4,
  parameter int NUM_REQ        = 4,
  parameter int COMPUTE_CYCLES = 11
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_REQ-1:0]                         req_i,
  input  logic                                       abort_i,
  output logic [NUM_REQ-1:0]                         gnt_o,
  output logic [NUM_REQ-1:0]                         done_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ld_sel_o,
  output logic                                       ld_en_o,
  output logic                                       clr_o,
  output logic                                       cmp_en_o,
  output logic [N-1:0]                               acc_valid_o,
  output logic                                       busy_o
);

  localparam int SW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC = (N > COMPUTE_CYCLES) ? N : COMPUTE_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [SW-1:0]        last_gnt_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [SW-1:0]        ld_sel_q;
  logic                 ld_en_q;
  logic                 clr_q;
  logic                 cmp_en_q;
  logic [N-1:0]         acc_valid_q;
  logic                 busy_q;

  // Round-robin search: first active requester at last_gnt+1, +2, ...
  // wrapping modulo NUM_REQ; the previous owner is checked last.
  logic          win_found;
  logic [SW-1:0] win_idx;
  logic [SW-1:0] cand_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = last_gnt_q;
    cand_idx  = last_gnt_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = SW'((int'(last_gnt_q) + i) % NUM_REQ);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  logic in_job;
  assign in_job = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_DRAIN);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_gnt_q  <= SW'(NUM_REQ - 1);
      gnt_q       <= '0;
      done_q      <= '0;
      ld_sel_q    <= '0;
      ld_en_q     <= 1'b0;
      clr_q       <= 1'b0;
      cmp_en_q    <= 1'b0;
      acc_valid_q <= '0;
      busy_q      <= 1'b0;
    end else if (abort_i && in_job) begin
      // Abort beats any phase-end transition; last_gnt keeps the aborted
      // owner so it does not get an immediate second chance.
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      gnt_q       <= '0;
      ld_en_q     <= 1'b0;
      clr_q       <= 1'b0;
      cmp_en_q    <= 1'b0;
      acc_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            state_q    <= S_LOAD;
            cnt_q      <= '0;
            gnt_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            ld_sel_q   <= win_idx;
            last_gnt_q <= win_idx;
            ld_en_q    <= 1'b1;
            clr_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_LOAD: begin
          clr_q <= 1'b0;
          if (cnt_q == CW'(N - 1)) begin
            state_q  <= S_COMPUTE;
            cnt_q    <= '0;
            ld_en_q  <= 1'b0;
            cmp_en_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_COMPUTE: begin
          if (cnt_q == CW'(COMPUTE_CYCLES - 1)) begin
            state_q     <= S_DRAIN;
            cnt_q       <= '0;
            cmp_en_q    <= 1'b0;
            acc_valid_q <= {{(N-1){1'b0}}, 1'b1};
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt_q == CW'(N - 1)) begin
            state_q     <= S_DONE;
            cnt_q       <= '0;
            acc_valid_q <= '0;
            done_q      <= gnt_q;
          end else begin
            cnt_q       <= cnt_q + 1'b1;
            acc_valid_q <= acc_valid_q << 1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          gnt_q   <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign ld_sel_o    = ld_sel_q;
  assign ld_en_o     = ld_en_q;
  assign clr_o       = clr_q;
  assign cmp_en_o    = cmp_en_q;
  assign acc_valid_o = acc_valid_q;
  assign busy_o      = busy_q;

endmodule
